remap_lut_multi: RTL and testbench
==================================

Name: remap_lut_multi

Overview:
Parametrised successor of the 7-bit remap register file: a DEPTH x DATA_W lookup table with one write port, N_CH independent registered lookup channels and a registered debug read port. It adds a sequential clear engine, one entry per cycle, that fills the table with zeros or an identity map, plus write acknowledge/drop handshakes. It sits between the host trigger/wire decode and the sensor channel-remap datapath.

Parameters:
DATA_W, 7, width of each table entry
ADDR_W, 7, address width; DEPTH = 2**ADDR_W entries
N_CH, 2, number of parallel lookup channels

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clr_start  in  1  pulse: start clear sweep
clr_identity  in  1  sampled with clr_start: 1 = entry i <= i, 0 = entry i <= 0
busy  out  1  clear sweep in progress
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  pulse, cycle after an accepted write
wr_drop  out  1  pulse, cycle after a rejected write
lk_valid  in  1  lookup request, all channels
lk_addr  in  N_CH*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W]
lk_data  out  N_CH*DATA_W  channel c result at [c*DATA_W +: DATA_W]
lk_data_valid  out  1  lk_data valid
lk_miss  out  1  pulse, lookup rejected because busy
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  registered table[dbg_addr]

Behaviour:
- FSM states: IDLE, CLEAR. Sweep counter clr_ptr is ADDR_W+1 bits wide.
- reset high: FSM to CLEAR, clr_ptr=0, clear mode=zero, busy=1; wr_ack, wr_drop, lk_data_valid, lk_miss, lk_data and dbg_data all =0. Table contents are not touched while reset is high.
- After reset falls: the zero sweep writes table[clr_ptr] each cycle for DEPTH cycles. busy drops in the cycle after the write to DEPTH-1, so busy stays high for DEPTH cycles after reset release.
- Reset asserted mid-sweep restarts the sweep from 0 in zero mode.
- CLEAR write value: 0, or identity. Identity is clr_ptr truncated to DATA_W LSBs when DATA_W<ADDR_W, zero-extended otherwise.
- clr_start in IDLE: go to CLEAR next cycle with clr_ptr=0, latching clr_identity. clr_start in CLEAR restarts from 0 with the newly sampled mode.
- Write accepted when wr_en=1, busy=0 and clr_start=0. The table updates at that edge; wr_ack=1 on the next cycle.
- wr_en while busy=1, or in the same cycle as clr_start: write is discarded and wr_drop=1 next cycle. wr_ack and wr_drop are never high together.
- Lookup: lk_valid=1 with busy=0 gives lk_data=table[lk_addr_c] for each channel and lk_data_valid=1 one cycle later. Latency is exactly 1; back-to-back lookups give one result per cycle.
- lk_valid=1 with busy=1: lk_data_valid=0 and lk_miss=1 next cycle; lk_data holds its previous value.
- Without lk_valid, lk_data holds its value and lk_data_valid=0.
- Read-during-write, same address same edge: lookups and dbg_data return the OLD entry; the new value is visible from the next request.
- dbg_data = table[dbg_addr] registered every cycle, including during busy (shows partial sweep state).
- Channels may use identical addresses; there is no arbitration and all are served in the same cycle.
- Table is a register array, one write per cycle from either the write port or the sweep, never both.

Test Plan:
- Reset 2 cycles then release, DATA_W=ADDR_W=7 -> busy high exactly 128 cycles after release; then lookups of addr 0, 64, 127 return 0 with lk_data_valid=1 one cycle after lk_valid.
- Idle: write addr 5 <- 0x2A, then lk_addr ch0=5, ch1=5 -> wr_ack one cycle after the write; both channels return 0x2A, 1-cycle latency.
- Same edge: write addr 9 <- 0x11 with lk_addr ch0=9 (old 0x03) -> lk_data ch0=0x03; repeat the lookup next cycle -> 0x11.
- clr_start with clr_identity=1, then wr_en at sweep cycle 10 and lk_valid at sweep cycle 20 -> wr_drop=1 and lk_miss=1, table unchanged by the write; after 128 cycles lookup addr 100 -> 100.
- DATA_W=4, ADDR_W=6 identity clear -> addr 0x23 returns 0x3 (truncation); clr_start reissued at sweep cycle 30 -> busy lasts 30+64 cycles total.
- Reset asserted at sweep cycle 40 of an identity clear -> sweep restarts in zero mode; after completion addr 20 reads 0, and dbg_data tracks the sweep progress throughout.

Source files
------------

// File: rtl/remap_lut_multi.sv
// Multi-channel remap lookup table with a one-entry-per-cycle clear sweep,
// acknowledged write port, N_CH registered lookup channels and a debug read port.
module remap_lut_multi #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 7,
  parameter int N_CH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_start,
  input  logic                     clr_identity,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic                     wr_drop,
  input  logic                     lk_valid,
  input  logic [N_CH*ADDR_W-1:0]   lk_addr,
  output logic [N_CH*DATA_W-1:0]   lk_data,
  output logic                     lk_data_valid,
  output logic                     lk_miss,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         clr_ptr_q, clr_ptr_d;
  logic                    clr_id_q, clr_id_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    wr_drop_q, wr_drop_d;
  logic [N_CH*DATA_W-1:0]  lk_data_q, lk_data_d;
  logic                    lk_data_valid_q, lk_data_valid_d;
  logic                    lk_miss_q, lk_miss_d;
  logic [DATA_W-1:0]       dbg_data_q, dbg_data_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    wr_accept;

  assign busy = (state_q == CLEAR);

  // Sweep control and the single table write port (sweep has priority).
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_id_d  = clr_id_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    wr_accept = wr_en && !busy && !clr_start;

    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q[ADDR_W-1:0];
      mem_wdata = clr_id_q ? DATA_W'(clr_ptr_q[ADDR_W-1:0]) : '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == (ADDR_W+1)'(DEPTH - 1)) begin
        state_d = IDLE;
      end
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end

    if (clr_start) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
      clr_id_d  = clr_identity;
    end

    // The table is left untouched while reset is held.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Response registers; table reads see the pre-write contents at each edge.
  always_comb begin
    wr_ack_d        = wr_accept;
    wr_drop_d       = wr_en && !wr_accept;
    lk_data_valid_d = lk_valid && !busy;
    lk_miss_d       = lk_valid && busy;
    lk_data_d       = lk_data_q;
    dbg_data_d      = mem_q[dbg_addr];
    if (lk_valid && !busy) begin
      for (int c = 0; c < N_CH; c++) begin
        lk_data_d[c*DATA_W +: DATA_W] = mem_q[lk_addr[c*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q         <= CLEAR;
      clr_ptr_q       <= '0;
      clr_id_q        <= 1'b0;
      wr_ack_q        <= 1'b0;
      wr_drop_q       <= 1'b0;
      lk_data_q       <= '0;
      lk_data_valid_q <= 1'b0;
      lk_miss_q       <= 1'b0;
      dbg_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      clr_ptr_q       <= clr_ptr_d;
      clr_id_q        <= clr_id_d;
      wr_ack_q        <= wr_ack_d;
      wr_drop_q       <= wr_drop_d;
      lk_data_q       <= lk_data_d;
      lk_data_valid_q <= lk_data_valid_d;
      lk_miss_q       <= lk_miss_d;
      dbg_data_q      <= dbg_data_d;
    end
  end

  // NOTE: the table has no reset; the clear sweep initialises it after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign wr_ack        = wr_ack_q;
  assign wr_drop       = wr_drop_q;
  assign lk_data       = lk_data_q;
  assign lk_data_valid = lk_data_valid_q;
  assign lk_miss       = lk_miss_q;
  assign dbg_data      = dbg_data_q;

endmodule

// File: tb/tb_remap_lut_multi.sv
// Scoreboard bench for remap_lut_multi: a 7x7 instance checked against a
// behavioural table model, plus a DATA_W=4/ADDR_W=6 instance for truncation.
module tb_remap_lut_multi;

  localparam int AW = 7, DW = 7, NA = 128;
  localparam int BAW = 6, BDW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int vectors = 0;
  int fails   = 0;

  // ---------------- instance A (7x7) ----------------
  logic            reset_a, clr_start_a, clr_id_a, busy_a;
  logic            wr_en_a, wr_ack_a, wr_drop_a;
  logic [AW-1:0]   wr_addr_a, dbg_addr_a;
  logic [DW-1:0]   wr_data_a, dbg_data_a;
  logic            lk_valid_a, lk_dv_a, lk_miss_a;
  logic [2*AW-1:0] lk_addr_a;
  logic [2*DW-1:0] lk_data_a;

  remap_lut_multi #(.DATA_W(DW), .ADDR_W(AW), .N_CH(2)) u_a (
    .clk(clk), .reset(reset_a), .clr_start(clr_start_a), .clr_identity(clr_id_a),
    .busy(busy_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wr_ack(wr_ack_a), .wr_drop(wr_drop_a), .lk_valid(lk_valid_a),
    .lk_addr(lk_addr_a), .lk_data(lk_data_a), .lk_data_valid(lk_dv_a),
    .lk_miss(lk_miss_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  // ---------------- instance B (4-bit data, 6-bit address) ----------------
  logic             reset_b, clr_start_b, clr_id_b, busy_b;
  logic             wr_en_b, wr_ack_b, wr_drop_b;
  logic [BAW-1:0]   wr_addr_b, dbg_addr_b;
  logic [BDW-1:0]   wr_data_b, dbg_data_b;
  logic             lk_valid_b, lk_dv_b, lk_miss_b;
  logic [2*BAW-1:0] lk_addr_b;
  logic [2*BDW-1:0] lk_data_b;

  remap_lut_multi #(.DATA_W(BDW), .ADDR_W(BAW), .N_CH(2)) u_b (
    .clk(clk), .reset(reset_b), .clr_start(clr_start_b), .clr_identity(clr_id_b),
    .busy(busy_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ack(wr_ack_b), .wr_drop(wr_drop_b), .lk_valid(lk_valid_b),
    .lk_addr(lk_addr_b), .lk_data(lk_data_b), .lk_data_valid(lk_dv_b),
    .lk_miss(lk_miss_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model and scoreboard queues for A ----------------
  typedef struct { int cyc; bit busy; bit rst; bit dbg_care; logic [DW-1:0] dbg; } cyc_exp_t;
  typedef struct { int cyc; bit miss; logic [2*DW-1:0] data; } lk_exp_t;
  typedef struct { int cyc; bit drop; } wr_exp_t;

  cyc_exp_t cq[$];
  lk_exp_t  lkq[$];
  wr_exp_t  wq[$];

  int            ref_mem [NA];
  bit            ref_known [NA];
  bit            sweeping;
  int            pos;
  bit            mode_id;
  logic [2*DW-1:0] last_lk;

  // Apply the current A inputs for one clock: predict responses, update the model.
  task automatic cycle_a();
    cyc_exp_t c;
    lk_exp_t  l;
    wr_exp_t  w;
    logic [2*DW-1:0] rd;
    int e;
    e = cyc_cnt + 1;
    c.cyc = e;
    c.rst = reset_a;
    c.dbg_care = reset_a ? 1'b1 : ref_known[dbg_addr_a];
    c.dbg = reset_a ? '0 : DW'(ref_mem[dbg_addr_a]);
    if (reset_a) begin
      sweeping = 1'b1;
      pos      = 0;
      mode_id  = 1'b0;
      last_lk  = '0;
    end else begin
      if (lk_valid_a) begin
        l.cyc = e;
        if (sweeping) begin
          l.miss = 1'b1;
          l.data = last_lk;
        end else begin
          for (int ch = 0; ch < 2; ch++) rd[ch*DW +: DW] = DW'(ref_mem[lk_addr_a[ch*AW +: AW]]);
          l.miss  = 1'b0;
          l.data  = rd;
          last_lk = rd;
        end
        lkq.push_back(l);
      end
      if (wr_en_a) begin
        w.cyc  = e;
        w.drop = sweeping || clr_start_a;
        wq.push_back(w);
      end
      if (sweeping) begin
        ref_mem[pos]   = mode_id ? pos : 0;
        ref_known[pos] = 1'b1;
        pos++;
        if (pos == NA) sweeping = 1'b0;
      end else if (wr_en_a && !clr_start_a) begin
        ref_mem[wr_addr_a]   = int'(wr_data_a);
        ref_known[wr_addr_a] = 1'b1;
      end
      if (clr_start_a) begin
        sweeping = 1'b1;
        pos      = 0;
        mode_id  = clr_id_a;
      end
    end
    c.busy = sweeping;
    cq.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    clr_start_a = 0; wr_en_a = 0; lk_valid_a = 0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    idle_a();
    while (busy_a && n < 300) begin cycle_a(); n++; end
    if (n >= 300) cmp(name, 32'(busy_a), 32'd0);
  endtask

  // ---------------- monitor for A ----------------
  always @(negedge clk) begin
    cyc_exp_t c;
    lk_exp_t  l;
    wr_exp_t  w;
    if (cq.size() > 0 && cq[0].cyc == cyc_cnt) begin
      c = cq.pop_front();
      cmp("busy", 32'(busy_a), 32'(c.busy));
      if (c.dbg_care) cmp("dbg_data", 32'(dbg_data_a), 32'(c.dbg));
      if (c.rst) cmp("reset_outputs", 32'({wr_ack_a, wr_drop_a, lk_dv_a, lk_miss_a, lk_data_a}), 32'd0);
    end
    while (lkq.size() > 0 && lkq[0].cyc < cyc_cnt) begin
      cmp("lk_response_present", 32'd0, 32'd1);
      void'(lkq.pop_front());
    end
    if (lk_dv_a || lk_miss_a) begin
      if (lkq.size() == 0 || lkq[0].cyc != cyc_cnt) cmp("lk_unexpected_response", 32'd1, 32'd0);
      else begin
        l = lkq.pop_front();
        cmp("lk_miss", 32'(lk_miss_a), 32'(l.miss));
        cmp("lk_data_valid", 32'(lk_dv_a), 32'(!l.miss));
        cmp("lk_data", 32'(lk_data_a), 32'(l.data));
      end
    end else if (lkq.size() > 0 && lkq[0].cyc == cyc_cnt) begin
      cmp("lk_response_present", 32'd0, 32'd1);
      void'(lkq.pop_front());
    end
    while (wq.size() > 0 && wq[0].cyc < cyc_cnt) begin
      cmp("wr_response_present", 32'd0, 32'd1);
      void'(wq.pop_front());
    end
    if (wr_ack_a || wr_drop_a) begin
      cmp("ack_drop_exclusive", 32'(wr_ack_a && wr_drop_a), 32'd0);
      if (wq.size() == 0 || wq[0].cyc != cyc_cnt) cmp("wr_unexpected_response", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        cmp("wr_drop", 32'(wr_drop_a), 32'(w.drop));
        cmp("wr_ack", 32'(wr_ack_a), 32'(!w.drop));
      end
    end else if (wq.size() > 0 && wq[0].cyc == cyc_cnt) begin
      cmp("wr_response_present", 32'd0, 32'd1);
      void'(wq.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_a = 1; idle_a(); clr_id_a = 0;
    wr_addr_a = '0; wr_data_a = '0; lk_addr_a = '0; dbg_addr_a = '0;
    reset_b = 1; clr_start_b = 0; clr_id_b = 0; wr_en_b = 0; wr_addr_b = '0;
    wr_data_b = '0; lk_valid_b = 0; lk_addr_b = '0; dbg_addr_b = '0;
    sweeping = 0; pos = 0; mode_id = 0; last_lk = '0;
    for (int i = 0; i < NA; i++) begin ref_mem[i] = 0; ref_known[i] = 0; end
    @(negedge clk);

    // Reset for two cycles; busy must then last exactly 128 cycles.
    cycle_a(); cycle_a();
    reset_a = 0;
    n = 0;
    while (busy_a && n < 300) begin cycle_a(); n++; end
    cmp("busy_cycles_after_reset", 32'(n), 32'd128);

    // Lookups of 0, 64, 127 after the zero sweep.
    lk_valid_a = 1; lk_addr_a = {7'd64, 7'd0}; cycle_a();
    lk_addr_a = {7'd127, 7'd127}; cycle_a();
    idle_a(); cycle_a();

    // Write 5 <- 0x2A, then both channels look up 5.
    wr_en_a = 1; wr_addr_a = 7'd5; wr_data_a = 7'h2A; cycle_a();
    idle_a(); lk_valid_a = 1; lk_addr_a = {7'd5, 7'd5}; cycle_a();
    idle_a(); cycle_a();

    // Same-edge read/write: old value first, new value on the next request.
    wr_en_a = 1; wr_addr_a = 7'd9; wr_data_a = 7'h03; cycle_a();
    wr_data_a = 7'h11; lk_valid_a = 1; lk_addr_a = {7'd5, 7'd9}; dbg_addr_a = 7'd9; cycle_a();
    wr_en_a = 0; cycle_a();
    idle_a(); cycle_a();

    // Randomised traffic with occasional clear sweeps.
    for (int i = 0; i < 400; i++) begin
      wr_en_a     = ($urandom_range(0, 2) == 0);
      wr_addr_a   = AW'($urandom);
      wr_data_a   = DW'($urandom);
      lk_valid_a  = $urandom_range(0, 1) == 1;
      lk_addr_a   = (2*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) lk_addr_a[AW-1:0] = wr_addr_a;
      dbg_addr_a  = AW'($urandom);
      clr_start_a = ($urandom_range(0, 149) == 0);
      clr_id_a    = $urandom_range(0, 1) == 1;
      cycle_a();
    end
    wait_idle_a("wait_random_sweep_done");

    // Identity sweep: write at sweep cycle 10 and lookup at 20 are rejected.
    clr_start_a = 1; clr_id_a = 1; cycle_a();
    clr_start_a = 0;
    for (int i = 0; i < NA; i++) begin
      wr_en_a = (i == 10); wr_addr_a = 7'd100; wr_data_a = 7'h55;
      lk_valid_a = (i == 20); lk_addr_a = {7'd1, 7'd100};
      dbg_addr_a = AW'(i);
      cycle_a();
    end
    idle_a();
    cmp("busy_after_identity_sweep", 32'(busy_a), 32'd0);
    lk_valid_a = 1; lk_addr_a = {7'd3, 7'd100}; cycle_a();
    idle_a(); cycle_a();

    // Reset at sweep cycle 40 of an identity clear restarts in zero mode.
    clr_start_a = 1; clr_id_a = 1; cycle_a();
    clr_start_a = 0;
    for (int i = 0; i < 40; i++) begin dbg_addr_a = AW'($urandom); cycle_a(); end
    reset_a = 1; cycle_a();
    reset_a = 0;
    n = 0;
    while (busy_a && n < 300) begin dbg_addr_a = AW'($urandom_range(0, 60)); cycle_a(); n++; end
    cmp("busy_cycles_after_mid_reset", 32'(n), 32'd128);
    lk_valid_a = 1; lk_addr_a = {7'd50, 7'd20}; cycle_a();
    idle_a(); cycle_a(); cycle_a();

    // Instance B: identity sweep truncated to 4 bits, restarted at busy cycle 30.
    reset_b = 0;
    n = 0;
    while (busy_b && n < 200) begin step_b(); n++; end
    cmp("b_busy_cycles_after_reset", 32'(n), 32'd64);
    clr_start_b = 1; clr_id_b = 1; step_b();
    clr_start_b = 0;
    n = 0;
    while (busy_b && n < 300) begin
      n++;
      clr_start_b = (n == 30);
      step_b();
    end
    clr_start_b = 0;
    cmp("b_busy_with_restart", 32'(n), 32'd94);
    lk_valid_b = 1; lk_addr_b = {6'd10, 6'h23}; dbg_addr_b = 6'h3F; step_b();
    lk_valid_b = 0;
    cmp("b_lk_data_valid", 32'(lk_dv_b), 32'd1);
    cmp("b_lk_ch0_trunc", 32'(lk_data_b[3:0]), 32'h3);
    cmp("b_lk_ch1", 32'(lk_data_b[7:4]), 32'hA);
    cmp("b_dbg_trunc", 32'(dbg_data_b), 32'hF);
    step_b();
    cmp("b_lk_data_valid_drop", 32'(lk_dv_b), 32'd0);
    cmp("b_lk_data_hold", 32'(lk_data_b), 32'hA3);

    step_b(); step_b();
    cmp("lk_queue_drained", 32'(lkq.size()), 32'd0);
    cmp("wr_queue_drained", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
